code_patch_unit: RTL and testbench
==================================

# code_patch_unit

Parametrised ROM code-patch unit. Holds NUM_REGS programmable address/data patch entries and compares every instruction-fetch address against them. On a match it substitutes the patch data for the ROM read data one cycle later. It sits between the ROM read port and the fetch path, and adds per-entry enables, a configuration lock state machine, error reporting and a saturating hit counter beyond the single-flag patch core.

## Interface
Parameters:
- ADDR_WIDTH, 32, fetch address width
- DATA_WIDTH, 12, ROM/patch data width
- NUM_REGS, 21, number of patch entries (1..64)
- CNT_WIDTH, 16, hit counter width
- SUB_REGS_DATA_WIDTH, max(ADDR_WIDTH, DATA_WIDTH), configuration write-data width
- IDX_W (localparam), max(1, $clog2(NUM_REGS))

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_ni  in  1  reset, asynchronous and active-low.
- cfg_we_i  in  1  configuration write strobe
- cfg_idx_i  in  IDX_W  entry index
- cfg_sel_i  in  2  00 = address, 01 = data, 10 = enable (wdata[0]), 11 = reserved
- cfg_wdata_i  in  SUB_REGS_DATA_WIDTH  write data
- cfg_lock_i  in  1  lock request (level, sampled each cycle)
- cfg_pat_gen_i  in  1  global patch enable
- si_valid_i  in  1  fetch valid
- si_addr_i  in  ADDR_WIDTH  fetch address
- si_rdata_i  in  DATA_WIDTH  original ROM data for si_addr_i, same cycle
- so_valid_o  out  1  output valid
- so_rdata_o  out  DATA_WIDTH  patched or original data
- so_hit_o  out  1  output data was substituted
- so_idx_o  out  IDX_W  index of the matching entry (0 when no hit)
- nopg_o  out  1  last completed fetch was not patched
- hit_cnt_o  out  CNT_WIDTH  saturating count of patched fetches
- cfg_locked_o  out  1  configuration locked
- cfg_err_o  out  1  one-cycle pulse on a rejected write

## Operation
- Each entry holds addr[ADDR_WIDTH], data[DATA_WIDTH] and en. All are reset to 0.
- Address writes take the low ADDR_WIDTH bits of cfg_wdata_i. Data writes take the low DATA_WIDTH bits.
- Lock state machine:
  - UNLOCKED → LOCKED when cfg_lock_i = 1.
  - LOCKED is left only by reset.
  - cfg_locked_o = (state == LOCKED).
- A write is rejected, with cfg_err_o pulsed and no state change, when any of these holds:
  - state is LOCKED
  - cfg_idx_i ≥ NUM_REGS
  - cfg_sel_i = 11
- When cfg_we_i and cfg_lock_i rise in the same cycle while UNLOCKED, the write is accepted and the lock takes effect from the next cycle.
- Match for entry i: en[i] & (addr[i] == si_addr_i), using a full-width compare.
- Hit condition: cfg_pat_gen_i & si_valid_i & any match.
- Priority: the lowest matching index wins.
- On a hit: so_rdata_o = data[idx], so_hit_o = 1, so_idx_o = idx.
- Otherwise: so_rdata_o = si_rdata_i, so_hit_o = 0, so_idx_o = 0.
- nopg_o updates only on a registered valid fetch: it becomes !hit. It holds its value between fetches.
- hit_cnt_o increments by 1 per hit and saturates at 2^CNT_WIDTH−1 (no wrap).

## Timing
- Lookup latency is 1 cycle: a fetch sampled at edge N appears on so_* after edge N.
- so_valid_o is si_valid_i delayed by one cycle. There is no backpressure: one fetch can be accepted per cycle, back-to-back.
- When so_valid_o = 0, so_rdata_o, so_hit_o and so_idx_o hold their last values.
- A configuration write at edge N affects fetches sampled at edge N+1 onward. A fetch sampled at edge N sees the pre-write entry.
- cfg_pat_gen_i is sampled together with the fetch.
- cfg_err_o is asserted for exactly the cycle after the rejected write.
- Reset values: so_valid_o 0, so_rdata_o 0, so_hit_o 0, so_idx_o 0, nopg_o 1, hit_cnt_o 0, cfg_locked_o 0, cfg_err_o 0.
- Reset asserted mid-stream clears everything asynchronously, including the lock. A fetch in flight is dropped (so_valid_o = 0).

## Test plan
- Basic patch:
  - Stimulus: write entry 3 with addr 0x0000_1000, data 0xABC, en 1; assert cfg_pat_gen_i; fetch 0x1000 with si_rdata_i 0x123.
  - Required: on the next cycle so_rdata_o = 0xABC, so_hit_o = 1, so_idx_o = 3, nopg_o = 0, hit_cnt_o = 1.
  - Then fetch 0x1004: so_rdata_o = ROM data, nopg_o = 1.
- Priority and enable:
  - Stimulus: program entries 2 and 5 with the same addr 0x2000, data 0x111 and 0x555 respectively.
  - Required: a fetch returns 0x111 with idx 2.
  - Then disable entry 2: the same fetch returns 0x555 with idx 5.
  - Then deassert cfg_pat_gen_i: the fetch returns ROM data, so_hit_o = 0.
- Write/fetch collision:
  - Stimulus: in the same cycle, write entry 0 with addr 0x3000 (en already 1) and fetch 0x3000.
  - Required: that fetch misses; a fetch of 0x3000 in the next cycle hits.
- Lock:
  - Stimulus: pulse cfg_lock_i, then attempt to write entry 1.
  - Required: cfg_locked_o = 1, cfg_err_o pulses for one cycle, entry 1 is unchanged.
  - Write with cfg_idx_i = 21 or cfg_sel_i = 11 while unlocked: also pulses cfg_err_o.
  - Assert rst_ni low: the lock clears.
- Counter saturation:
  - Stimulus: CNT_WIDTH = 4; issue 20 back-to-back hitting fetches.
  - Required: so_valid_o is high for 20 consecutive cycles and hit_cnt_o stops at 15.
- Async reset mid-stream:
  - Stimulus: drop rst_ni between clock edges during a fetch burst.
  - Required: all outputs take their reset values immediately, and all entries read back as disabled after release.

Source files
------------

// File: rtl/code_patch_unit.sv
// ROM code-patch unit: programmable address/data patch entries that are compared
// against every fetch address. On a match the patch data replaces the ROM data on
// the registered output one cycle later. A lock FSM freezes the configuration,
// and a saturating counter tracks the number of patched fetches.
module code_patch_unit #(
  parameter int ADDR_WIDTH          = 32,
  parameter int DATA_WIDTH          = 12,
  parameter int NUM_REGS            = 21,
  parameter int CNT_WIDTH           = 16,
  parameter int SUB_REGS_DATA_WIDTH = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH,
  localparam int IDX_W              = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           cfg_we_i,
  input  logic [IDX_W-1:0]               cfg_idx_i,
  input  logic [1:0]                     cfg_sel_i,
  input  logic [SUB_REGS_DATA_WIDTH-1:0] cfg_wdata_i,
  input  logic                           cfg_lock_i,
  input  logic                           cfg_pat_gen_i,
  input  logic                           si_valid_i,
  input  logic [ADDR_WIDTH-1:0]          si_addr_i,
  input  logic [DATA_WIDTH-1:0]          si_rdata_i,
  output logic                           so_valid_o,
  output logic [DATA_WIDTH-1:0]          so_rdata_o,
  output logic                           so_hit_o,
  output logic [IDX_W-1:0]               so_idx_o,
  output logic                           nopg_o,
  output logic [CNT_WIDTH-1:0]           hit_cnt_o,
  output logic                           cfg_locked_o,
  output logic                           cfg_err_o
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  localparam logic [1:0] SEL_ADDR = 2'b00;
  localparam logic [1:0] SEL_DATA = 2'b01;
  localparam logic [1:0] SEL_EN   = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  lock_state_t state, state_next;

  logic [ADDR_WIDTH-1:0] entry_addr [NUM_REGS];
  logic [DATA_WIDTH-1:0] entry_data [NUM_REGS];
  logic [NUM_REGS-1:0]   entry_en;
  logic [NUM_REGS-1:0]   match;

  logic                  idx_in_range;
  logic                  wr_ok;
  logic                  wr_err;
  logic                  any_match;
  logic [IDX_W-1:0]      match_idx;
  logic                  hit;

  // Widen by one bit so the range check cannot overflow when NUM_REGS is a power of two.
  assign idx_in_range = ({1'b0, cfg_idx_i} < (IDX_W + 1)'(NUM_REGS));

  // A write lands only while unlocked, in range and with a defined selector.
  assign wr_ok  = cfg_we_i && (state == UNLOCKED) && idx_in_range && (cfg_sel_i != SEL_RSVD);
  assign wr_err = cfg_we_i && !wr_ok;

  // Lock state register; only reset leaves LOCKED.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= UNLOCKED;
    else         state <= state_next;
  end

  // Lock next-state: a level on cfg_lock_i locks from the following cycle.
  always_comb begin
    state_next = state;
    if (state == UNLOCKED && cfg_lock_i) state_next = LOCKED;
  end

  assign cfg_locked_o = (state == LOCKED);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      logic sel_this;
      assign sel_this = wr_ok && (cfg_idx_i == IDX_W'(gi));

      // Entry storage; a write at edge N is visible to fetches sampled from N+1.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          entry_addr[gi] <= '0;
          entry_data[gi] <= '0;
          entry_en[gi]   <= 1'b0;
        end else if (sel_this) begin
          case (cfg_sel_i)
            SEL_ADDR: entry_addr[gi] <= cfg_wdata_i[ADDR_WIDTH-1:0];
            SEL_DATA: entry_data[gi] <= cfg_wdata_i[DATA_WIDTH-1:0];
            SEL_EN:   entry_en[gi]   <= cfg_wdata_i[0];
            default:  ;
          endcase
        end
      end

      assign match[gi] = entry_en[gi] && (entry_addr[gi] == si_addr_i);
    end
  endgenerate

  // Priority encoder: scanning downward leaves the lowest matching index.
  always_comb begin
    any_match = 1'b0;
    match_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (match[i]) begin
        any_match = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  assign hit = cfg_pat_gen_i && si_valid_i && any_match;

  // Output stage: payload updates only on a valid fetch and holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      so_valid_o <= 1'b0;
      so_rdata_o <= '0;
      so_hit_o   <= 1'b0;
      so_idx_o   <= '0;
      nopg_o     <= 1'b1;
    end else begin
      so_valid_o <= si_valid_i;
      if (si_valid_i) begin
        so_rdata_o <= hit ? entry_data[match_idx] : si_rdata_i;
        so_hit_o   <= hit;
        so_idx_o   <= hit ? match_idx : '0;
        nopg_o     <= !hit;
      end
    end
  end

  // Saturating hit counter; it sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                   hit_cnt_o <= '0;
    else if (hit && (hit_cnt_o != {CNT_WIDTH{1'b1}})) hit_cnt_o <= hit_cnt_o + 1'b1;
  end

  // Rejected-write pulse, one cycle after the offending write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cfg_err_o <= 1'b0;
    else         cfg_err_o <= wr_err;
  end

endmodule

// File: tb/tb_code_patch_unit.sv
// Directed testbench for code_patch_unit (NUM_REGS = 21, CNT_WIDTH = 4).
module tb_code_patch_unit;

  localparam int AW    = 32;
  localparam int DW    = 12;
  localparam int NR    = 21;
  localparam int CW    = 4;
  localparam int IW    = 5;
  localparam int SW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [1:0]    cfg_sel;
  logic [SW-1:0] cfg_wdata;
  logic          cfg_lock;
  logic          pat_gen;
  logic          si_valid;
  logic [AW-1:0] si_addr;
  logic [DW-1:0] si_rdata;
  logic          so_valid;
  logic [DW-1:0] so_rdata;
  logic          so_hit;
  logic [IW-1:0] so_idx;
  logic          nopg;
  logic [CW-1:0] hit_cnt;
  logic          locked;
  logic          cfg_err;

  int checks = 0;
  int errors = 0;

  code_patch_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .CNT_WIDTH(CW), .SUB_REGS_DATA_WIDTH(SW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx), .cfg_sel_i(cfg_sel), .cfg_wdata_i(cfg_wdata),
    .cfg_lock_i(cfg_lock), .cfg_pat_gen_i(pat_gen),
    .si_valid_i(si_valid), .si_addr_i(si_addr), .si_rdata_i(si_rdata),
    .so_valid_o(so_valid), .so_rdata_o(so_rdata), .so_hit_o(so_hit), .so_idx_o(so_idx),
    .nopg_o(nopg), .hit_cnt_o(hit_cnt), .cfg_locked_o(locked), .cfg_err_o(cfg_err)
  );

  always #5 clk = ~clk;

  // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [IW-1:0] idx, input logic [1:0] sel, input logic [SW-1:0] wd);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = wd;
    step();
    cfg_we = 1'b0;
    $display("cfg write idx=%0d sel=%0d wdata=%h err=%b", idx, sel, wd, cfg_err);
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] rd);
    si_valid = 1'b1; si_addr = a; si_rdata = rd;
    step();
    si_valid = 1'b0;
    $display("fetch addr=%h rom=%h -> valid=%b data=%h hit=%b idx=%0d nopg=%b cnt=%0d",
             a, rd, so_valid, so_rdata, so_hit, so_idx, nopg, hit_cnt);
  endtask

  task automatic program_entry(input logic [IW-1:0] idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_write(idx, 2'b00, a);
    cfg_write(idx, 2'b01, {20'h0, d});
    cfg_write(idx, 2'b10, 32'h1);
  endtask

  task automatic test_reset();
    checks++; if (so_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", so_valid); end
    checks++; if (so_rdata !== 12'h000) begin errors++; $display("FAIL reset_rdata got %h exp 000", so_rdata); end
    checks++; if (so_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %b exp 0", so_hit); end
    checks++; if (so_idx !== 5'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", so_idx); end
    checks++; if (nopg !== 1'b1) begin errors++; $display("FAIL reset_nopg got %b exp 1", nopg); end
    checks++; if (hit_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", hit_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b exp 0", locked); end
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", cfg_err); end
  endtask

  task automatic test_basic_patch();
    program_entry(5'd3, 32'h0000_1000, 12'hABC);
    pat_gen = 1'b1;
    fetch(32'h0000_1000, 12'h123);
    checks++; if (so_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", so_valid); end
    checks++; if (so_rdata !== 12'hABC) begin errors++; $display("FAIL basic_rdata got %h exp abc", so_rdata); end
    checks++; if (so_hit !== 1'b1) begin errors++; $display("FAIL basic_hit got %b exp 1", so_hit); end
    checks++; if (so_idx !== 5'd3) begin errors++; $display("FAIL basic_idx got %0d exp 3", so_idx); end
    checks++; if (nopg !== 1'b0) begin errors++; $display("FAIL basic_nopg got %b exp 0", nopg); end
    checks++; if (hit_cnt !== 4'd1) begin errors++; $display("FAIL basic_cnt got %0d exp 1", hit_cnt); end
    fetch(32'h0000_1004, 12'h456);
    checks++; if (so_rdata !== 12'h456) begin errors++; $display("FAIL miss_rdata got %h exp 456", so_rdata); end
    checks++; if (so_hit !== 1'b0) begin errors++; $display("FAIL miss_hit got %b exp 0", so_hit); end
    checks++; if (so_idx !== 5'd0) begin errors++; $display("FAIL miss_idx got %0d exp 0", so_idx); end
    checks++; if (nopg !== 1'b1) begin errors++; $display("FAIL miss_nopg got %b exp 1", nopg); end
    checks++; if (hit_cnt !== 4'd1) begin errors++; $display("FAIL miss_cnt got %0d exp 1", hit_cnt); end
    // Idle cycle: valid drops, payload and nopg hold.
    si_rdata = 12'hFFF;
    step();
    checks++; if (so_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", so_valid); end
    checks++; if (so_rdata !== 12'h456) begin errors++; $display("FAIL idle_hold_rdata got %h exp 456", so_rdata); end
    checks++; if (nopg !== 1'b1) begin errors++; $display("FAIL idle_hold_nopg got %b exp 1", nopg); end
  endtask

  task automatic test_priority_enable();
    program_entry(5'd2, 32'h0000_2000, 12'h111);
    program_entry(5'd5, 32'h0000_2000, 12'h555);
    fetch(32'h0000_2000, 12'h777);
    checks++; if (so_rdata !== 12'h111) begin errors++; $display("FAIL prio_rdata got %h exp 111", so_rdata); end
    checks++; if (so_idx !== 5'd2) begin errors++; $display("FAIL prio_idx got %0d exp 2", so_idx); end
    cfg_write(5'd2, 2'b10, 32'h0);
    fetch(32'h0000_2000, 12'h777);
    checks++; if (so_rdata !== 12'h555) begin errors++; $display("FAIL dis_rdata got %h exp 555", so_rdata); end
    checks++; if (so_idx !== 5'd5) begin errors++; $display("FAIL dis_idx got %0d exp 5", so_idx); end
    checks++; if (hit_cnt !== 4'd3) begin errors++; $display("FAIL dis_cnt got %0d exp 3", hit_cnt); end
    pat_gen = 1'b0;
    fetch(32'h0000_2000, 12'h777);
    checks++; if (so_rdata !== 12'h777) begin errors++; $display("FAIL nopat_rdata got %h exp 777", so_rdata); end
    checks++; if (so_hit !== 1'b0) begin errors++; $display("FAIL nopat_hit got %b exp 0", so_hit); end
    checks++; if (hit_cnt !== 4'd3) begin errors++; $display("FAIL nopat_cnt got %0d exp 3", hit_cnt); end
    pat_gen = 1'b1;
  endtask

  task automatic test_collision();
    cfg_write(5'd0, 2'b10, 32'h1);
    // Same cycle: entry 0 address write and a fetch of the new address.
    cfg_we = 1'b1; cfg_idx = 5'd0; cfg_sel = 2'b00; cfg_wdata = 32'h0000_3000;
    si_valid = 1'b1; si_addr = 32'h0000_3000; si_rdata = 12'h0AA;
    step();
    cfg_we = 1'b0; si_valid = 1'b0;
    $display("collision write+fetch addr=00003000 -> data=%h hit=%b", so_rdata, so_hit);
    checks++; if (so_hit !== 1'b0) begin errors++; $display("FAIL coll_hit got %b exp 0", so_hit); end
    checks++; if (so_rdata !== 12'h0AA) begin errors++; $display("FAIL coll_rdata got %h exp 0aa", so_rdata); end
    fetch(32'h0000_3000, 12'h0AA);
    checks++; if (so_hit !== 1'b1) begin errors++; $display("FAIL after_coll_hit got %b exp 1", so_hit); end
    checks++; if (so_rdata !== 12'h000) begin errors++; $display("FAIL after_coll_rdata got %h exp 000", so_rdata); end
    checks++; if (so_idx !== 5'd0) begin errors++; $display("FAIL after_coll_idx got %0d exp 0", so_idx); end
    checks++; if (hit_cnt !== 4'd4) begin errors++; $display("FAIL after_coll_cnt got %0d exp 4", hit_cnt); end
  endtask

  task automatic test_back_to_back();
    int exp_cnt;
    exp_cnt = 4;
    si_valid = 1'b1; si_addr = 32'h0000_1000; si_rdata = 12'h321;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      $display("b2b fetch %0d -> valid=%b data=%h cnt=%0d", i, so_valid, so_rdata, hit_cnt);
      checks++; if (so_valid !== 1'b1 || so_rdata !== 12'hABC) begin
        errors++; $display("FAIL b2b_%0d valid/data got %b/%h exp 1/abc", i, so_valid, so_rdata);
      end
      checks++; if (hit_cnt !== CW'(exp_cnt)) begin
        errors++; $display("FAIL b2b_cnt_%0d got %0d exp %0d", i, hit_cnt, exp_cnt);
      end
    end
    si_valid = 1'b0;
    step();
    checks++; if (hit_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", hit_cnt); end
  endtask

  task automatic test_lock();
    cfg_write(5'd21, 2'b00, 32'h0000_4000);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_idx got %b exp 1", cfg_err); end
    cfg_write(5'd1, 2'b11, 32'h0000_4000);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_sel got %b exp 1", cfg_err); end
    cfg_write(5'd1, 2'b00, 32'h0000_4000);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL ok_write_err got %b exp 0", cfg_err); end
    cfg_write(5'd1, 2'b10, 32'h1);
    // Data write together with the lock request: accepted, lock next cycle.
    cfg_lock = 1'b1;
    cfg_write(5'd1, 2'b01, 32'h0000_0444);
    cfg_lock = 1'b0;
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL lock_same_cycle_err got %b exp 0", cfg_err); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL locked got %b exp 1", locked); end
    cfg_write(5'd1, 2'b01, 32'h0000_0999);
    checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL locked_err got %b exp 1", cfg_err); end
    step();
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_pulse_len got %b exp 0", cfg_err); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_held got %b exp 1", locked); end
    fetch(32'h0000_4000, 12'h010);
    checks++; if (so_rdata !== 12'h444) begin errors++; $display("FAIL locked_entry_rdata got %h exp 444", so_rdata); end
    checks++; if (so_idx !== 5'd1) begin errors++; $display("FAIL locked_entry_idx got %0d exp 1", so_idx); end
  endtask

  task automatic test_async_reset();
    si_valid = 1'b1; si_addr = 32'h0000_1000; si_rdata = 12'h222;
    step();
    step();
    #3;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-burst");
    checks++; if (so_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", so_valid); end
    checks++; if (so_rdata !== 12'h000) begin errors++; $display("FAIL ar_rdata got %h exp 000", so_rdata); end
    checks++; if (so_hit !== 1'b0) begin errors++; $display("FAIL ar_hit got %b exp 0", so_hit); end
    checks++; if (nopg !== 1'b1) begin errors++; $display("FAIL ar_nopg got %b exp 1", nopg); end
    checks++; if (hit_cnt !== 4'd0) begin errors++; $display("FAIL ar_cnt got %0d exp 0", hit_cnt); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL ar_locked got %b exp 0", locked); end
    si_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    fetch(32'h0000_1000, 12'h201);
    checks++; if (so_hit !== 1'b0 || so_rdata !== 12'h201) begin
      errors++; $display("FAIL ar_e3_cleared hit/data got %b/%h exp 0/201", so_hit, so_rdata);
    end
    fetch(32'h0000_4000, 12'h202);
    checks++; if (so_hit !== 1'b0 || so_rdata !== 12'h202) begin
      errors++; $display("FAIL ar_e1_cleared hit/data got %b/%h exp 0/202", so_hit, so_rdata);
    end
    fetch(32'h0000_0000, 12'h203);
    checks++; if (so_hit !== 1'b0 || so_rdata !== 12'h203) begin
      errors++; $display("FAIL ar_e0_cleared hit/data got %b/%h exp 0/203", so_hit, so_rdata);
    end
    // The lock was cleared, so configuration works again.
    program_entry(5'd1, 32'h0000_5000, 12'h5A5);
    checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL ar_write_err got %b exp 0", cfg_err); end
    fetch(32'h0000_5000, 12'h204);
    checks++; if (so_rdata !== 12'h5A5 || so_idx !== 5'd1) begin
      errors++; $display("FAIL ar_reprog data/idx got %h/%0d exp 5a5/1", so_rdata, so_idx);
    end
    checks++; if (hit_cnt !== 4'd1) begin errors++; $display("FAIL ar_reprog_cnt got %0d exp 1", hit_cnt); end
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_wdata = '0;
    cfg_lock = 1'b0; pat_gen = 1'b0; si_valid = 1'b0; si_addr = '0; si_rdata = '0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic_patch();
    test_priority_enable();
    test_collision();
    test_back_to_back();
    test_lock();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
